// File: rtl/upower_decode_alu.sv
// uPower decode + execute stage: field split, ALU op select, 64-bit ALU.
// Optional shifter (sld/srd/srad) enabled by defining UPOWER_SHIFT_EN.
module upower_decode_alu (
  input  logic        clock,
  input  logic        rst_n,
  input  logic        in_valid,
  input  logic [31:0] instruction,
  input  logic [63:0] rs_content,
  input  logic [63:0] rt_content,
  input  logic [1:0]  ALUop,
  input  logic        ALUSrc,
  output logic        out_valid,
  output logic [5:0]  po,
  output logic [4:0]  rd,
  output logic [4:0]  bo,
  output logic [4:0]  rs,
  output logic [4:0]  bi,
  output logic [4:0]  rt,
  output logic        oe,
  output logic [9:0]  xox,
  output logic [8:0]  xoxo,
  output logic        aa,
  output logic        lk,
  output logic        rc,
  output logic [15:0] si,
  output logic [13:0] bd,
  output logic [23:0] li,
  output logic [1:0]  xods,
  output logic [63:0] ds,
  output logic [3:0]  ALUInput,
  output logic [63:0] alu_result,
  output logic        flag,
  output logic        illegal
);

  localparam logic [3:0] OP_AND   = 4'b0000;
  localparam logic [3:0] OP_OR    = 4'b0001;
  localparam logic [3:0] OP_ADD   = 4'b0010;
  localparam logic [3:0] OP_XOR   = 4'b0011;
  localparam logic [3:0] OP_NAND  = 4'b0100;
  localparam logic [3:0] OP_NOR   = 4'b0101;
  localparam logic [3:0] OP_SUB   = 4'b0110;
  localparam logic [3:0] OP_EXTSW = 4'b0111;
  localparam logic [3:0] OP_SLD   = 4'b1000;
  localparam logic [3:0] OP_SRD   = 4'b1001;
  localparam logic [3:0] OP_SRAD  = 4'b1010;
  localparam logic [3:0] OP_ILL   = 4'b1111;

  logic [5:0]  c_po;
  logic [9:0]  c_xox;
  logic [8:0]  c_xoxo;
  logic [15:0] c_si;
  logic [63:0] c_ds;
  logic [63:0] a;
  logic [63:0] b;
  logic [63:0] c_res;
  logic [3:0]  c_op;
  logic        c_ill;

  assign c_po   = instruction[31:26];
  assign c_xox  = instruction[10:1];
  assign c_xoxo = instruction[9:1];
  assign c_si   = instruction[15:0];

  always_comb begin
    c_ds = {{48{c_si[15]}}, c_si};
    if (c_po == 6'd24 || c_po == 6'd26 || c_po == 6'd28)
      c_ds = {48'd0, c_si};
    else if (c_po == 6'd58 || c_po == 6'd62)
      c_ds = {{48{instruction[15]}}, instruction[15:2], 2'b00};
  end

  always_comb begin
    c_op = OP_ILL;
    case (ALUop)
      2'b00: c_op = OP_ADD;
      2'b01: c_op = OP_SUB;
      2'b11: begin
        unique case (1'b1)
          c_po == 6'd28: c_op = OP_AND;
          c_po == 6'd24: c_op = OP_OR;
          c_po == 6'd26: c_op = OP_XOR;
          default:       c_op = OP_ILL;
        endcase
      end
      2'b10: begin
        // XO-form (9-bit) opcodes win over X-form (10-bit) ones
        if (c_xoxo == 9'd266)
          c_op = OP_ADD;
        else if (c_xoxo == 9'd40)
          c_op = OP_SUB;
        else begin
          case (c_xox)
            10'd28:  c_op = OP_AND;
            10'd444: c_op = OP_OR;
            10'd316: c_op = OP_XOR;
            10'd476: c_op = OP_NAND;
            10'd124: c_op = OP_NOR;
            10'd986: c_op = OP_EXTSW;
`ifdef UPOWER_SHIFT_EN
            10'd27:  c_op = OP_SLD;
            10'd539: c_op = OP_SRD;
            10'd794: c_op = OP_SRAD;
`endif
            default: c_op = OP_ILL;
          endcase
        end
      end
      default: c_op = OP_ILL;
    endcase
  end

  assign a     = rs_content;
  assign b     = ALUSrc ? c_ds : rt_content;
  assign c_ill = (c_op == OP_ILL);

`ifdef UPOWER_SHIFT_EN
  logic signed [63:0] sa;
  logic [63:0]        sra;
  assign sa  = a;
  assign sra = sa >>> b[5:0];
`endif

  always_comb begin
    c_res = '0;
    case (c_op)
      OP_AND:   c_res = a & b;
      OP_OR:    c_res = a | b;
      OP_ADD:   c_res = a + b;
      OP_XOR:   c_res = a ^ b;
      OP_NAND:  c_res = ~(a & b);
      OP_NOR:   c_res = ~(a | b);
      OP_SUB:   c_res = b - a;
      OP_EXTSW: c_res = {{32{a[31]}}, a[31:0]};
`ifdef UPOWER_SHIFT_EN
      OP_SLD:   c_res = b[6] ? '0 : a << b[5:0];
      OP_SRD:   c_res = b[6] ? '0 : a >> b[5:0];
      OP_SRAD:  c_res = b[6] ? {64{a[63]}} : sra;
`endif
      default:  c_res = '0;
    endcase
  end

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      out_valid  <= 1'b0;
      po         <= '0;
      rd         <= '0;
      bo         <= '0;
      rs         <= '0;
      bi         <= '0;
      rt         <= '0;
      oe         <= 1'b0;
      xox        <= '0;
      xoxo       <= '0;
      aa         <= 1'b0;
      lk         <= 1'b0;
      rc         <= 1'b0;
      si         <= '0;
      bd         <= '0;
      li         <= '0;
      xods       <= '0;
      ds         <= '0;
      ALUInput   <= '0;
      alu_result <= '0;
      flag       <= 1'b0;
      illegal    <= 1'b0;
    end else begin
      out_valid  <= in_valid;
      po         <= c_po;
      rd         <= instruction[25:21];
      bo         <= instruction[25:21];
      rs         <= instruction[20:16];
      bi         <= instruction[20:16];
      rt         <= instruction[15:11];
      oe         <= instruction[10];
      xox        <= c_xox;
      xoxo       <= c_xoxo;
      aa         <= instruction[1];
      lk         <= instruction[0];
      rc         <= instruction[0];
      si         <= c_si;
      bd         <= instruction[15:2];
      li         <= instruction[25:2];
      xods       <= instruction[1:0];
      ds         <= c_ds;
      ALUInput   <= c_op;
      alu_result <= c_res;
      flag       <= !c_ill && (c_res == 64'd0);
      illegal    <= c_ill;
    end
  end

endmodule

// File: tb/tb_upower_decode_alu.sv
// Bench for upower_decode_alu: vector table, scoreboard queue, reset cases.
// Shift expectations follow UPOWER_SHIFT_EN.
module tb_upower_decode_alu;

  logic        clock;
  logic        rst_n;
  logic        in_valid;
  logic [31:0] instruction;
  logic [63:0] rs_content;
  logic [63:0] rt_content;
  logic [1:0]  ALUop;
  logic        ALUSrc;
  logic        out_valid;
  logic [5:0]  po;
  logic [4:0]  rd, bo, rs, bi, rt;
  logic        oe;
  logic [9:0]  xox;
  logic [8:0]  xoxo;
  logic        aa, lk, rc;
  logic [15:0] si;
  logic [13:0] bd;
  logic [23:0] li;
  logic [1:0]  xods;
  logic [63:0] ds;
  logic [3:0]  ALUInput;
  logic [63:0] alu_result;
  logic        flag;
  logic        illegal;

  upower_decode_alu dut (
    .clock(clock),
    .rst_n(rst_n),
    .in_valid(in_valid),
    .instruction(instruction),
    .rs_content(rs_content),
    .rt_content(rt_content),
    .ALUop(ALUop),
    .ALUSrc(ALUSrc),
    .out_valid(out_valid),
    .po(po),
    .rd(rd),
    .bo(bo),
    .rs(rs),
    .bi(bi),
    .rt(rt),
    .oe(oe),
    .xox(xox),
    .xoxo(xoxo),
    .aa(aa),
    .lk(lk),
    .rc(rc),
    .si(si),
    .bd(bd),
    .li(li),
    .xods(xods),
    .ds(ds),
    .ALUInput(ALUInput),
    .alu_result(alu_result),
    .flag(flag),
    .illegal(illegal)
  );

  typedef struct {
    logic [31:0] ins;
    logic [63:0] a;
    logic [63:0] b;
    logic [1:0]  op;
    logic        src;
    logic        v;
    logic [63:0] ds;
    logic [3:0]  alu;
    logic [63:0] res;
    logic        ill;
  } vec_t;

  vec_t tbl[$];
  vec_t sb[$];
  int   n_chk  = 0;
  int   n_fail = 0;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  function automatic vec_t mk(
    input logic [31:0] ins, input logic [63:0] a, input logic [63:0] b,
    input logic [1:0] op, input logic src, input logic v,
    input logic [63:0] ds_e, input logic [3:0] alu, input logic [63:0] res,
    input logic ill);
    vec_t e;
    e.ins = ins; e.a = a; e.b = b; e.op = op; e.src = src; e.v = v;
    e.ds = ds_e; e.alu = alu; e.res = res; e.ill = ill;
    return e;
  endfunction

  task automatic cmp(input string name, input logic [127:0] act,
                     input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t e);
    in_valid    = e.v;
    instruction = e.ins;
    rs_content  = e.a;
    rt_content  = e.b;
    ALUop       = e.op;
    ALUSrc      = e.src;
    sb.push_back(e);
  endtask

  task automatic check(input vec_t e);
    cmp("out_valid", out_valid, e.v);
    cmp("po", po, e.ins[31:26]);
    cmp("rd_bo", {rd, bo}, {e.ins[25:21], e.ins[25:21]});
    cmp("rs_bi_rt", {rs, bi, rt}, {e.ins[20:16], e.ins[20:16], e.ins[15:11]});
    cmp("xo_fields", {oe, xox, xoxo, aa, lk, rc},
        {e.ins[10], e.ins[10:1], e.ins[9:1], e.ins[1], e.ins[0], e.ins[0]});
    cmp("imm_fields", {si, bd, li, xods},
        {e.ins[15:0], e.ins[15:2], e.ins[25:2], e.ins[1:0]});
    cmp("ds", ds, e.ds);
    cmp("ALUInput", ALUInput, e.alu);
    cmp("alu_result", alu_result, e.res);
    cmp("flag", flag, (e.res == 64'd0) && !e.ill);
    cmp("illegal", illegal, e.ill);
  endtask

  task automatic collect();
    @(posedge clock);
    #1;
    if (sb.size() == 0) cmp("scoreboard_empty", 1, 0);
    else check(sb.pop_front());
  endtask

  task automatic chk_zero(input string tag);
    cmp({tag, "_valid"}, out_valid, 0);
    cmp({tag, "_result"}, alu_result, 0);
    cmp({tag, "_ds_po_li"}, {ds, po, li}, 0);
    cmp({tag, "_op_flag_ill"}, {ALUInput, flag, illegal}, 0);
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; instruction = '0;
    rs_content = '0; rt_content = '0; ALUop = '0; ALUSrc = 1'b0;

    tbl.push_back(mk(32'h3861FFFF, 64'd5, 64'd0, 2'b00, 1, 1,
                     64'hFFFF_FFFF_FFFF_FFFF, 4'b0010, 64'd4, 0));
    tbl.push_back(mk(32'h7C811214, 64'd7, 64'd8, 2'b10, 0, 1,
                     64'h1214, 4'b0010, 64'd15, 0));
    tbl.push_back(mk(32'h7C000000, 64'd9, 64'd9, 2'b01, 0, 1,
                     64'd0, 4'b0110, 64'd0, 0));
    tbl.push_back(mk(32'h70008001, 64'hFFFF, 64'd0, 2'b11, 1, 1,
                     64'h8001, 4'b0000, 64'h8001, 0));
    tbl.push_back(mk(32'h600000F0, 64'h0F00, 64'd0, 2'b11, 1, 1,
                     64'hF0, 4'b0001, 64'hFF0, 0));
    tbl.push_back(mk(32'h6800FFFF, 64'hFFFF_0000_0000_00FF, 64'd0, 2'b11, 1, 1,
                     64'hFFFF, 4'b0011, 64'hFFFF_0000_0000_FF00, 0));
    tbl.push_back(mk(32'h7C0007D0, 64'd3, 64'd4, 2'b10, 0, 1,
                     64'h7D0, 4'b1111, 64'd0, 1));
    tbl.push_back(mk(32'h38000000, 64'd0, 64'd0, 2'b11, 0, 1,
                     64'd0, 4'b1111, 64'd0, 1));
    tbl.push_back(mk(32'h7C000450, 64'd10, 64'd3, 2'b10, 0, 1,
                     64'h450, 4'b0110, 64'hFFFF_FFFF_FFFF_FFF9, 0));
    tbl.push_back(mk(32'h7C0003B8, 64'hF0F0, 64'hFF00, 2'b10, 0, 1,
                     64'h3B8, 4'b0100, 64'hFFFF_FFFF_FFFF_0FFF, 0));
    tbl.push_back(mk(32'h7C0000F8, 64'd0, 64'd0, 2'b10, 0, 1,
                     64'hF8, 4'b0101, 64'hFFFF_FFFF_FFFF_FFFF, 0));
    tbl.push_back(mk(32'h7C0007B4, 64'h8000_0001, 64'd0, 2'b10, 0, 1,
                     64'h7B4, 4'b0111, 64'hFFFF_FFFF_8000_0001, 0));
    tbl.push_back(mk(32'h7C000038, 64'hFF, 64'h0F, 2'b10, 0, 1,
                     64'h38, 4'b0000, 64'h0F, 0));
    tbl.push_back(mk(32'h7C000378, 64'hF0, 64'h0F, 2'b10, 0, 1,
                     64'h378, 4'b0001, 64'hFF, 0));
    tbl.push_back(mk(32'h7C000278, 64'd5, 64'd5, 2'b10, 0, 1,
                     64'h278, 4'b0011, 64'd0, 0));
    tbl.push_back(mk(32'hE800FFFD, 64'h10, 64'd0, 2'b00, 1, 1,
                     64'hFFFF_FFFF_FFFF_FFFC, 4'b0010, 64'hC, 0));
    tbl.push_back(mk(32'h38000000, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 2'b00, 0, 1,
                     64'd0, 4'b0010, 64'd0, 0));
    tbl.push_back(mk(32'h7C811214, 64'd1, 64'd2, 2'b10, 0, 0,
                     64'h1214, 4'b0010, 64'd3, 0));
`ifdef UPOWER_SHIFT_EN
    tbl.push_back(mk(32'h7C000634, 64'h8000_0000_0000_0000, 64'd4, 2'b10, 0, 1,
                     64'h634, 4'b1010, 64'hF800_0000_0000_0000, 0));
    tbl.push_back(mk(32'h7C000634, 64'h8000_0000_0000_0000, 64'h40, 2'b10, 0, 1,
                     64'h634, 4'b1010, 64'hFFFF_FFFF_FFFF_FFFF, 0));
    tbl.push_back(mk(32'h7C000036, 64'd1, 64'h40, 2'b10, 0, 1,
                     64'h36, 4'b1000, 64'd0, 0));
    tbl.push_back(mk(32'h7C000036, 64'd1, 64'd5, 2'b10, 0, 1,
                     64'h36, 4'b1000, 64'h20, 0));
    tbl.push_back(mk(32'h7C000436, 64'h8000_0000_0000_0000, 64'd63, 2'b10, 0, 1,
                     64'h436, 4'b1001, 64'd1, 0));
`else
    tbl.push_back(mk(32'h7C000634, 64'h8000_0000_0000_0000, 64'd4, 2'b10, 0, 1,
                     64'h634, 4'b1111, 64'd0, 1));
    tbl.push_back(mk(32'h7C000036, 64'd1, 64'd5, 2'b10, 0, 1,
                     64'h36, 4'b1111, 64'd0, 1));
    tbl.push_back(mk(32'h7C000436, 64'h8000_0000_0000_0000, 64'd63, 2'b10, 0, 1,
                     64'h436, 4'b1111, 64'd0, 1));
`endif

    // drive while in reset: nothing may be captured
    instruction = 32'h3861FFFF; rs_content = 64'd5; in_valid = 1'b1;
    ALUSrc = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    chk_zero("reset");

    foreach (tbl[i]) begin
      @(negedge clock);
      if (i == 0) rst_n = 1'b1;
      drive(tbl[i]);
      collect();
    end

    // async reset mid-stream discards the captured result
    @(negedge clock);
    drive(tbl[1]);
    @(posedge clock);
    #3;
    rst_n = 1'b0;
    #1;
    chk_zero("midreset");
    sb.delete();
    @(negedge clock);
    in_valid = 1'b1; instruction = 32'h7C000000;
    rs_content = 64'd1; rt_content = 64'd9; ALUop = 2'b01; ALUSrc = 1'b0;
    @(posedge clock);
    #1;
    chk_zero("held");

    // first capture happens on the first edge after release
    @(negedge clock);
    rst_n = 1'b1;
    drive(mk(32'h7C000000, 64'd1, 64'd9, 2'b01, 0, 1,
             64'd0, 4'b0110, 64'd8, 0));
    collect();
    @(negedge clock);
    drive(tbl[3]);
    collect();
    cmp("sb_drained", sb.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/upower_decode_alu.md
# upower_decode_alu

Combined decode-and-execute stage for the uPower 64-bit core. It splits a 32-bit uPower instruction into its fields, derives a 4-bit ALU operation from the `ALUop` class and the opcode/extended-opcode fields, and executes it on 64-bit register operands or an extended immediate. All results are registered: one clock of latency, with a valid flag travelling alongside the data. It sits between instruction fetch/register read and the memory/write-back logic.

## Interface
- No parameters.
- clock  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- in_valid  in  1  instruction/operands valid this cycle
- instruction  in  32  raw instruction word
- rs_content  in  64  operand A (RA register value)
- rt_content  in  64  operand B (RB register value)
- ALUop  in  2  class: 00 add, 01 sub/compare, 10 X/XO-decode, 11 D-form logical
- ALUSrc  in  1  1 = operand B is `ds` immediate
- out_valid  out  1  registered in_valid
- po  out  6  instr[31:26]
- rd / bo  out  5 each  instr[25:21]
- rs / bi  out  5 each  instr[20:16]
- rt  out  5  instr[15:11]
- oe  out  1  instr[10]
- xox  out  10  instr[10:1]
- xoxo  out  9  instr[9:1]
- aa  out  1  instr[1]
- lk, rc  out  1 each  instr[0]
- si  out  16  instr[15:0]
- bd  out  14  instr[15:2]
- li  out  24  instr[25:2]
- xods  out  2  instr[1:0]
- ds  out  64  extended immediate
- ALUInput  out  4  selected ALU operation
- alu_result  out  64  ALU result
- flag  out  1  1 when alu_result == 0
- illegal  out  1  unsupported operation

## Operation
- ds:
  - po 24/26/28 (ori/xori/andi): zero-extend si.
  - po 58/62 (DS-form): sign-extend {instr[15:2],2'b00}.
  - Otherwise: sign-extend si.
- ALUInput, by ALUop:
  - 00: 0010 add.
  - 01: 0110 sub.
  - 11: po 28 → 0000 and; po 24 → 0001 or; po 26 → 0011 xor; otherwise illegal.
- ALUop 10 decode. XO match first, then xox:
  - XO match: xoxo 266 → 0010 add; xoxo 40 → 0110 subf.
  - xox 28 and 0000; 444 or 0001; 316 xor 0011; 476 nand 0100; 124 nor 0101; 986 extsw 0111.
  - xox 27 sld 1000; 539 srd 1001; 794 srad 1010.
  - Any other value is illegal.
- Operands: a = rs_content; b = ALUSrc ? ds : rt_content.
- ALU:
  - add = a+b, wrapping mod 2^64.
  - sub/subf = b−a (ALUop 01 also uses b−a).
  - Bitwise ops as named; extsw sign-extends a[31:0].
  - Shifts:
    - sld: a << b[5:0], result 0 if b[6]=1.
    - srd: logical right by b[5:0], result 0 if b[6]=1.
    - srad: arithmetic right by b[5:0], all sign bits if b[6]=1.
- Illegal: ALUInput=1111, alu_result=0, flag=0, illegal=1.
- in_valid=0: the registers still update. out_valid=0 marks the data don't-care.

## Timing
- Decode and ALU are combinational. All outputs are registered on posedge clock: latency 1 cycle, throughput 1/cycle, no stall/back-pressure.
- rst_n low asynchronously clears every output to 0, including out_valid and flag.
- Reset asserted mid-stream discards the in-flight result.
- The first capture is on the first rising edge after rst_n rises.

## Configuration
- UPOWER_SHIFT_EN:
  - Defined: sld/srd/srad are decoded and executed.
  - Undefined: xox 27/539/794 decode as illegal, and no shifter is synthesized.

## Test plan
- Reset: rst_n=0 mid-operation → all outputs 0 immediately, out_valid=0.
- addi 0x3861FFFF, rs_content=5, ALUop=00, ALUSrc=1 → next cycle:
  - po=14, rd=3, rs=1.
  - ds=0xFFFF_FFFF_FFFF_FFFF, alu_result=4, flag=0.
- add 0x7C811214, rs_content=7, rt_content=8, ALUop=10, ALUSrc=0 → ALUInput=0010, alu_result=15.
- Compare: ALUop=01, rs_content=rt_content=9 → alu_result=0, flag=1.
- andi po 28, si=0x8001, rs_content=0xFFFF → ds=0x8001, alu_result=0x8001.
- X-form xox=1000 → illegal=1, alu_result=0. With the shift macro enabled, srad of 0x8000_0000_0000_0000 by 4 → 0xF800_0000_0000_0000.
